rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

- Shares the register file's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Also provides a clear sequencer that zeroes registers 1..NUM_REGS-1 without asserting the global reset.
- Sits between the multi-cycle CPU writeback logic and the register file.
- Its registered outputs drive the register file's RegWrite, Write_register and Write_data inputs directly.

## Interface
Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, register count; register 0 is hardwired zero

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- req0_valid  in  1  ALU write request
- req0_addr  in  ADDR_WIDTH  destination register
- req0_data  in  DATA_WIDTH  write data
- req0_ready  out  1  request accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, load path
- clr_start  in  1  start clear sequence (level, sampled in IDLE only)
- clr_busy  out  1  high while state is CLEAR
- clr_done  out  1  one-cycle pulse at end of clear
- RegWrite  out  1  register-file write enable (registered)
- Write_register  out  ADDR_WIDTH  register-file write address (registered)
- Write_data  out  DATA_WIDTH  register-file write data (registered)

## Operation
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start=1.
  - CLEAR -> IDLE after cnt reaches NUM_REGS-1.
- Handshake: transfer on reqN_valid && reqN_ready.
  - Requester holds valid, addr and data stable until ready.
  - valid never drops before acceptance.
- reqN_ready = (state==IDLE) && !clr_start && grantN. At most one ready high per cycle.
- Arbitration is 2-way round-robin:
  - Single valid: that requester wins.
  - Both valid: the one not granted last wins.
  - The last-grant pointer updates only on an accepted transfer. Reset value favours req0.
- Accepted write: the next cycle shows RegWrite=1 with the accepted addr/data for exactly one cycle.
  - Address 0: still accepted (ready=1), but RegWrite stays 0 and Write_register/Write_data hold their previous values.
- Same-address requests from both requesters: the winner writes first, the loser the next cycle, so the loser's data persists.
- clr_start and a request in the same IDLE cycle: clear wins, no grant, and the request waits.
- CLEAR: 5-bit counter cnt runs 1..NUM_REGS-1, one per cycle.
  - Each CLEAR cycle produces RegWrite=1, Write_register=cnt, Write_data=0 on the next cycle.
  - clr_start is ignored while in CLEAR.
- No output is ever combinationally dependent on the register-file contents.

## Timing
- Reset values (reset=0 at an edge):
  - state=IDLE, cnt=0, RegWrite=0, Write_register=0, Write_data=0, clr_done=0, clr_busy=0, round-robin pointer favours req0.
- Write latency: acceptance in cycle t gives RegWrite in cycle t+1, and the register-file update lands at the t+1 edge. Sustained throughput is 1 write per cycle.
- Clear sequence, with clr_start sampled in IDLE at cycle t:
  - cycles t+1..t+31: state=CLEAR, clr_busy=1, both readies 0.
  - cycles t+2..t+32: outputs show addresses 1..31, data 0.
  - cycle t+32: state=IDLE and clr_done=1, coinciding with the address-31 write. Requests may be accepted in t+32 and appear in t+33; there is no overlap with clear writes.
- Reset asserted mid-clear aborts the sequence:
  - RegWrite is 0 the next cycle.
  - clr_done does not pulse.
  - Partially cleared registers are left as-is.
- Reset during a pending request: the request is dropped and no write is issued.

## Structure
- Shared header rf_ctrl_defs.vh holds:
  - state encodings S_IDLE and S_CLEAR;
  - the REG_ZERO address constant;
  - default widths.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter.
  - Inputs: req[1:0] and an advance strobe.
  - Output: one-hot gnt[1:0].
  - Its pointer resets synchronously with the same active-low reset.
- Top level contains the FSM, clear counter, acceptance logic and output registers.

## Test plan
- req0 valid, addr 5, data 0xDEADBEEF, alone: req0_ready=1 the same cycle; the next cycle shows RegWrite=1, Write_register=5, Write_data=0xDEADBEEF; RegWrite=0 the cycle after.
- Both valid for 4 consecutive transfers, with req0 addr 3 and req1 addr 7 re-presented each time: grants alternate req0, req1, req0, req1; outputs show 3, 7, 3, 7 on back-to-back cycles.
- Both valid to addr 9 (req0 data 0x11, req1 data 0x22) after reset: req0 writes first, then req1; a final register-file read of r9 returns 0x22.
- req1 to addr 0, data 0x1234: req1_ready=1 and RegWrite stays 0; the register-file read of r0 returns 0.
- clr_start pulsed with req0 valid in the same cycle: 31 consecutive zero writes to addresses 1..31; clr_done high concurrent with addr 31; req0 accepted in that cycle and written the cycle after.
- reset=0 asserted at the 10th CLEAR cycle: RegWrite=0 the next cycle, clr_busy=0, no clr_done; r1..r9 are 0 and r10..r31 are unchanged.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: FSM encodings,
// the hardwired-zero register address and default widths.
package rf_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 32;
  localparam int REG_ZERO       = 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_arb.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant
// is actually consumed, and after reset req0 wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // 1 means req1 was granted last, so req0 wins the next tie
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (adv) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback
// and runs a sequencer that zeroes registers 1..NUM_REGS-1.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] Write_register,
  output logic [DATA_WIDTH-1:0] Write_data
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_clr_done;
  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_cnt_last;
  logic                  w_acc0;
  logic                  w_acc1;

  assign w_idle     = (r_state == S_IDLE);
  assign w_cnt_last = (r_cnt == ADDR_WIDTH'(NUM_REGS - 1));

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .adv   (w_acc0 | w_acc1),
    .gnt   (w_gnt)
  );

  // A clear request in IDLE takes priority; pending writes simply wait
  assign req0_ready = w_idle && !clr_start && w_gnt[0];
  assign req1_ready = w_idle && !clr_start && w_gnt[1];
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (clr_start) w_next_state = S_CLEAR;
      S_CLEAR: if (w_cnt_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_idle && clr_start) begin
      r_cnt <= ADDR_WIDTH'(1);
    end else if (!w_idle) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Writes to register 0 are accepted but leave the port untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regwrite <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_regwrite <= 1'b0;
      r_clr_done <= !w_idle && w_cnt_last;
      if (!w_idle) begin
        r_regwrite <= 1'b1;
        r_wr_addr  <= r_cnt;
        r_wr_data  <= '0;
      end else if (w_acc0 && (req0_addr != ADDR_WIDTH'(REG_ZERO))) begin
        r_regwrite <= 1'b1;
        r_wr_addr  <= req0_addr;
        r_wr_data  <= req0_data;
      end else if (w_acc1 && (req1_addr != ADDR_WIDTH'(REG_ZERO))) begin
        r_regwrite <= 1'b1;
        r_wr_addr  <= req1_addr;
        r_wr_data  <= req1_data;
      end
    end
  end

  assign clr_busy       = !w_idle;
  assign clr_done       = r_clr_done;
  assign RegWrite       = r_regwrite;
  assign Write_register = r_wr_addr;
  assign Write_data     = r_wr_data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table for arbitration plus sequences
// for clear, clear-with-request and reset during clear.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, clr_start;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, clr_busy, clr_done, RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  rf_write_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .clr_start      (clr_start),
    .clr_busy       (clr_busy),
    .clr_done       (clr_done),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data)
  );

  always #5 clk = ~clk;

  // Register file driven by the arbiter outputs, r0 hardwired to zero
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
  always @(posedge clk) if (RegWrite && Write_register != 5'd0) rf[Write_register] <= Write_data;
  function automatic logic [31:0] rf_read(input int a);
    return (a == 0) ? 32'd0 : rf[a];
  endfunction

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e0;
    logic        e1;
  } vec_t;
  vec_t tbl[12];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock cycle: check readies, predict the write, then check outputs
  task automatic cycle(input logic er0, input logic er1, input bit chk_rdy);
    wr_t e;
    #1;
    if (chk_rdy && reset) begin
      check("req0_ready", 32'(req0_ready), 32'(er0));
      check("req1_ready", 32'(req1_ready), 32'(er1));
    end
    if (reset && er0 && req0_valid && req0_addr != 5'd0) exp_q.push_back({req0_addr, req0_data});
    if (reset && er1 && req1_valid && req1_addr != 5'd0) exp_q.push_back({req1_addr, req1_data});
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_en", 32'(RegWrite), 32'd1);
      check("wr_addr", 32'(Write_register), 32'(e.a));
      check("wr_data", Write_data, e.d);
    end else begin
      check("wr_idle", 32'(RegWrite), 32'd0);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; clr_start = 0;
    req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      1, 0};
    tbl[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 0};
    tbl[2]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h1234,   0, 1};
    tbl[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 0};
    tbl[4]  = '{1, 5'd3,  32'h33,       1, 5'd7,  32'h77,     1, 0};
    tbl[5]  = '{1, 5'd3,  32'h33,       1, 5'd7,  32'h77,     0, 1};
    tbl[6]  = '{1, 5'd3,  32'h33,       1, 5'd7,  32'h77,     1, 0};
    tbl[7]  = '{1, 5'd3,  32'h33,       1, 5'd7,  32'h77,     0, 1};
    tbl[8]  = '{1, 5'd9,  32'h11,       1, 5'd9,  32'h22,     1, 0};
    tbl[9]  = '{0, 5'd0,  32'h0,        1, 5'd9,  32'h22,     0, 1};
    tbl[10] = '{0, 5'd0,  32'h0,        1, 5'd12, 32'hCAFE,   0, 1};
    tbl[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 0};

    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_waddr", 32'(Write_register), 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    reset = 1;

    // Arbitration vectors
    for (int i = 0; i < 12; i++) begin
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      cycle(tbl[i].e0, tbl[i].e1, 1);
    end
    idle_inputs();
    cycle(0, 0, 1);
    check("rf_r5", rf_read(5), 32'hDEADBEEF);
    check("rf_r3", rf_read(3), 32'h33);
    check("rf_r7", rf_read(7), 32'h77);
    check("rf_r9", rf_read(9), 32'h22);
    check("rf_r0", rf_read(0), 32'h0);
    check("rf_r12", rf_read(12), 32'hCAFE);

    // Clear start coinciding with a req0 request
    clr_start = 1; req0_valid = 1; req0_addr = 5'd4; req0_data = 32'hA5A5;
    cycle(0, 0, 1);
    clr_start = 0;
    for (int k = 1; k < 32; k++) begin
      check("clr_busy", 32'(clr_busy), 32'd1);
      check("clr_done_early", 32'(clr_done), 32'd0);
      exp_q.push_back({5'(k), 32'd0});
      cycle(0, 0, 1);
    end
    check("clr_busy_end", 32'(clr_busy), 32'd0);
    check("clr_done", 32'(clr_done), 32'd1);
    cycle(1, 0, 1);
    idle_inputs();
    check("clr_done_pulse", 32'(clr_done), 32'd0);
    cycle(0, 0, 1);
    check("rf_after_clr_r4", rf_read(4), 32'hA5A5);
    check("rf_after_clr_r1", rf_read(1), 32'h0);
    check("rf_after_clr_r31", rf_read(31), 32'h0);

    // Fill every register at one write per cycle
    for (int k = 1; k < 32; k++) begin
      req0_valid = 1; req0_addr = 5'(k); req0_data = 32'h100 + 32'(k);
      cycle(1, 0, 1);
    end
    idle_inputs();
    cycle(0, 0, 1);

    // Reset asserted at the 10th clear cycle
    clr_start = 1;
    cycle(0, 0, 1);
    clr_start = 0;
    for (int k = 1; k < 10; k++) begin
      exp_q.push_back({5'(k), 32'd0});
      cycle(0, 0, 1);
    end
    check("abort_busy_before", 32'(clr_busy), 32'd1);
    reset = 0;
    req1_valid = 1; req1_addr = 5'd20; req1_data = 32'hBAD;
    cycle(0, 0, 0);
    reset = 1;
    req1_valid = 0;
    check("abort_busy", 32'(clr_busy), 32'd0);
    check("abort_done", 32'(clr_done), 32'd0);
    check("abort_waddr", 32'(Write_register), 32'd0);
    check("abort_wdata", Write_data, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_done", 32'(clr_done), 32'd0);
      cycle(0, 0, 1);
    end
    for (int k = 1; k < 32; k++)
      check($sformatf("abort_rf_r%0d", k), rf_read(k), (k < 10) ? 32'd0 : 32'h100 + 32'(k));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
